// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame transmitter: opcodes, command
// encodings, serialiser states and the parity helper.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_REG_WR    = 8'hAA;
  localparam logic [7:0] CMD_REG_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_W_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NO_OP = 8'hDD;

  typedef enum logic [1:0] {
    CT_REG_WR    = 2'd0,
    CT_REG_RD    = 2'd1,
    CT_ALU_W_OP  = 2'd2,
    CT_ALU_NO_OP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_e;

  // Even parity when odd_sel=0, odd parity when odd_sel=1.
  function automatic logic char_parity(input logic [7:0] b, input logic odd_sel);
    return (^b) ^ odd_sel;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_tx_if.sv
// Command request handshake between a host and the UART command-frame
// transmitter.
interface uart_cmd_frame_tx_if #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4,
  parameter int FUN_WD  = 4
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_op_a;
  logic [DATA_WD-1:0] cmd_op_b;
  logic [FUN_WD-1:0]  cmd_fun;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_op_a, cmd_op_b, cmd_fun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_op_a, cmd_op_b, cmd_fun,
    output cmd_ready
  );

endinterface

// File: rtl/uart_cmd_frame_builder.sv
// Combinational frame builder: picks the byte at a given index of the latched
// command's frame and reports the frame length (2..4 bytes).
module uart_cmd_frame_builder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4,
  parameter int FUN_WD  = 4
) (
  input  cmd_type_e          i_cmd_type,
  input  logic [ADDR_WD-1:0] i_addr,
  input  logic [DATA_WD-1:0] i_op_a,
  input  logic [DATA_WD-1:0] i_op_b,
  input  logic [FUN_WD-1:0]  i_fun,
  input  logic [1:0]         i_byte_idx,
  output logic [DATA_WD-1:0] o_byte,
  output logic [2:0]         o_len
);

  logic [DATA_WD-1:0] w_addr_ext;
  logic [DATA_WD-1:0] w_fun_ext;

  assign w_addr_ext = DATA_WD'(i_addr);
  assign w_fun_ext  = DATA_WD'(i_fun);

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    o_byte = '0;
    o_len  = 3'd2;
    case (i_cmd_type)
      CT_REG_WR: begin
        o_len = 3'd3;
        case (i_byte_idx)
          2'd0:    o_byte = CMD_REG_WR;
          2'd1:    o_byte = w_addr_ext;
          default: o_byte = i_op_a;
        endcase
      end
      CT_REG_RD: begin
        o_len  = 3'd2;
        o_byte = (i_byte_idx == 2'd0) ? CMD_REG_RD : w_addr_ext;
      end
      CT_ALU_W_OP: begin
        o_len = 3'd4;
        case (i_byte_idx)
          2'd0:    o_byte = CMD_ALU_W_OP;
          2'd1:    o_byte = i_op_a;
          2'd2:    o_byte = i_op_b;
          default: o_byte = w_fun_ext;
        endcase
      end
      default: begin
        o_len  = 3'd2;
        o_byte = (i_byte_idx == 2'd0) ? CMD_ALU_NO_OP : w_fun_ext;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// UART command-frame transmitter: latches one command per handshake and
// serialises its frame bytes (start, 8 data LSB-first, optional parity, stop, gap).
module uart_cmd_frame_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WD   = 8,
  parameter int ADDR_WD   = 4,
  parameter int FUN_WD    = 4,
  parameter int BITCNT_WD = 16,
  parameter int GAP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_cmd_frame_tx_if.slave   cmd,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic [BITCNT_WD-1:0] clks_per_bit,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 byte_done,
  output logic                 frame_done
);

  localparam int              GAP_CW   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_e               r_state;
  cmd_type_e            r_cmd_type;
  logic [ADDR_WD-1:0]   r_addr;
  logic [DATA_WD-1:0]   r_op_a;
  logic [DATA_WD-1:0]   r_op_b;
  logic [FUN_WD-1:0]    r_fun;
  logic                 r_par_en;
  logic                 r_par_typ;
  logic [BITCNT_WD-1:0] r_bit_last;
  logic [BITCNT_WD-1:0] r_tim;
  logic [2:0]           r_bit_cnt;
  logic [GAP_CW-1:0]    r_gap_cnt;
  logic [1:0]           r_byte_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_frame_done;

  logic [DATA_WD-1:0]   w_byte;
  logic [2:0]           w_len;
  logic                 w_accept;
  logic                 w_tim_end;
  logic                 w_last_byte;
  logic                 w_char_end;

  uart_cmd_frame_builder #(
    .DATA_WD (DATA_WD),
    .ADDR_WD (ADDR_WD),
    .FUN_WD  (FUN_WD)
  ) u_builder (
    .i_cmd_type (r_cmd_type),
    .i_addr     (r_addr),
    .i_op_a     (r_op_a),
    .i_op_b     (r_op_b),
    .i_fun      (r_fun),
    .i_byte_idx (r_byte_idx),
    .o_byte     (w_byte),
    .o_len      (w_len)
  );

  assign w_accept    = (r_state == ST_IDLE) && cmd.cmd_valid;
  assign w_tim_end   = (r_tim == r_bit_last);
  assign w_last_byte = (r_byte_idx == 2'(w_len - 3'd1));
  assign w_char_end  = w_tim_end &&
                       (((r_state == ST_STOP) && (GAP_BITS == 0)) ||
                        ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST)));

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign tx_out        = r_tx;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign byte_done     = (r_state == ST_STOP) && w_tim_end;

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the block override earlier ones within the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_cmd_type   <= CT_REG_WR;
      r_addr       <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_fun        <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_bit_last   <= '0;
      r_tim        <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_byte_idx   <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // Bit timer reloads at P-1 so it can never wrap.
      if (r_state != ST_IDLE) r_tim <= w_tim_end ? '0 : r_tim + 1'b1;

      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cmd_type <= cmd_type_e'(cmd.cmd_type);
          r_addr     <= cmd.cmd_addr;
          r_op_a     <= cmd.cmd_op_a;
          r_op_b     <= cmd.cmd_op_b;
          r_fun      <= cmd.cmd_fun;
          r_par_en   <= par_en;
          r_par_typ  <= par_typ;
          r_bit_last <= (clks_per_bit == '0) ? '0 : clks_per_bit - 1'b1;
          r_tim      <= '0;
          r_byte_idx <= '0;
          r_tx       <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: if (w_tim_end) begin
          r_bit_cnt <= '0;
          r_tx      <= w_byte[0];
          r_state   <= ST_DATA;
        end
        ST_DATA: if (w_tim_end) begin
          if (r_bit_cnt == 3'd7) begin
            r_tx    <= r_par_en ? char_parity(w_byte, r_par_typ) : 1'b1;
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_tx      <= w_byte[r_bit_cnt + 3'd1];
          end
        end
        ST_PARITY: if (w_tim_end) begin
          r_tx    <= 1'b1;
          r_state <= ST_STOP;
        end
        ST_STOP: if (w_tim_end && (GAP_BITS != 0)) begin
          r_gap_cnt <= '0;
          r_state   <= ST_GAP;
        end
        ST_GAP: if (w_tim_end) r_gap_cnt <= r_gap_cnt + 1'b1;
        default: r_state <= ST_IDLE;
      endcase

      // End of a character (stop or last gap bit): next byte or frame end.
      if (w_char_end) begin
        if (w_last_byte) begin
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
          r_state      <= ST_IDLE;
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
          r_tx       <= 1'b0;
          r_state    <= ST_START;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Self-checking bench for uart_cmd_frame_tx: a line monitor decodes characters
// and compares them against a scoreboard filled when commands are issued.
module tb_uart_cmd_frame_tx;
  import uart_cmd_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        par_en, par_typ;
  logic [15:0] clks_per_bit;
  logic        tx_out, busy, byte_done, frame_done;

  always #5 CLK = ~CLK;

  uart_cmd_frame_tx_if #(.DATA_WD(8), .ADDR_WD(4), .FUN_WD(4)) cmd_if ();

  uart_cmd_frame_tx #(
    .DATA_WD(8), .ADDR_WD(4), .FUN_WD(4), .BITCNT_WD(16), .GAP_BITS(1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cmd          (cmd_if.slave),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .clks_per_bit (clks_per_bit),
    .tx_out       (tx_out),
    .busy         (busy),
    .byte_done    (byte_done),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       par_en;
    int         p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference frame contents, one scoreboard entry per character.
  task automatic push_frame(input logic [1:0] t, input logic [3:0] addr,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] fun, input logic pen,
                            input logic ptyp, input logic [15:0] cpb);
    logic [7:0] bytes[$];
    exp_t e;
    case (t)
      2'd0:    bytes = '{8'hAA, {4'h0, addr}, a};
      2'd1:    bytes = '{8'hBB, {4'h0, addr}};
      2'd2:    bytes = '{8'hCC, a, b, {4'h0, fun}};
      default: bytes = '{8'hDD, {4'h0, fun}};
    endcase
    foreach (bytes[i]) begin
      e.data   = bytes[i];
      e.par    = (^bytes[i]) ^ ptyp;
      e.par_en = pen;
      e.p      = (cpb == 16'd0) ? 1 : int'(cpb);
      sb.push_back(e);
    end
  endtask

  // Activity counters, sampled on the falling edge.
  int   bd_cnt, fd_cnt, busy_cyc, rdy_viol, fd_viol;
  logic prev_busy = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (byte_done) bd_cnt++;
      if (frame_done) begin
        fd_cnt++;
        if (busy || !prev_busy) fd_viol++;
      end
      if (busy) busy_cyc++;
      if (busy && cmd_if.cmd_ready) rdy_viol++;
    end
    prev_busy = busy;
  end

  // Line monitor: samples each bit at its midpoint.
  exp_t       m_exp;
  int         m_cyc;
  int         m_k;
  logic       m_active = 1'b0;
  logic [7:0] m_data;
  logic       m_par;

  always @(negedge CLK) begin
    if (RST) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        if (tx_out === 1'b0) begin
          if (sb.size() == 0) begin
            check("spurious_start", 32'(tx_out), 32'd1);
          end else begin
            m_exp    = sb.pop_front();
            m_active = 1'b1;
            m_cyc    = 0;
          end
        end
      end else begin
        m_cyc++;
      end
      if (m_active && (m_cyc % m_exp.p == m_exp.p / 2)) begin
        m_k = m_cyc / m_exp.p;
        if (m_k == 0) check("start_bit", 32'(tx_out), 32'd0);
        else if (m_k <= 8) m_data[m_k-1] = tx_out;
        else if (m_k == 9 && m_exp.par_en) m_par = tx_out;
        if (m_k == (m_exp.par_en ? 10 : 9)) begin
          check("byte", 32'(m_data), 32'(m_exp.data));
          if (m_exp.par_en) check("parity", 32'(m_par), 32'(m_exp.par));
          check("stop_bit", 32'(tx_out), 32'd1);
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic clear_counts();
    bd_cnt = 0; fd_cnt = 0; busy_cyc = 0; rdy_viol = 0; fd_viol = 0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [3:0] addr,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fun, input logic pen,
                       input logic ptyp, input logic [15:0] cpb);
    cmd_if.cmd_type = t;
    cmd_if.cmd_addr = addr;
    cmd_if.cmd_op_a = a;
    cmd_if.cmd_op_b = b;
    cmd_if.cmd_fun  = fun;
    par_en          = pen;
    par_typ         = ptyp;
    clks_per_bit    = cpb;
  endtask

  task automatic send(input logic [1:0] t, input logic [3:0] addr,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] fun, input logic pen,
                      input logic ptyp, input logic [15:0] cpb);
    int guard = 0;
    while (!cmd_if.cmd_ready && guard < 5000) begin
      cycle();
      guard++;
    end
    if (guard >= 5000) check("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
    drive(t, addr, a, b, fun, pen, ptyp, cpb);
    push_frame(t, addr, a, b, fun, pen, ptyp, cpb);
    cmd_if.cmd_valid = 1'b1;
    cycle();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    if (fd_cnt < target) check("frame_timeout", 32'(fd_cnt), 32'(target));
    repeat (2) cycle();
  endtask

  task automatic check_frame(input string tag, input int exp_busy, input int exp_bd,
                             input int exp_fd);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    check({tag, "_byte_done"}, 32'(bd_cnt), 32'(exp_bd));
    check({tag, "_frame_done"}, 32'(fd_cnt), 32'(exp_fd));
    check({tag, "_ready_low"}, 32'(rdy_viol), 32'd0);
    check({tag, "_fd_edge"}, 32'(fd_viol), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int viol;
    int n;
    RST              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    drive(2'd0, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 16'd4);
    clear_counts();
    repeat (3) cycle();
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_done", 32'(byte_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    RST = 1'b0;

    // Idle line with no command.
    viol = 0;
    repeat (100) begin
      @(negedge CLK);
      if (tx_out !== 1'b1 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("idle_100", 32'(viol), 32'd0);
    cycle();

    // REG_WR, P=4, no parity.
    clear_counts();
    send(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 16'd4);
    wait_frame(1, 1000);
    check_frame("reg_wr", 132, 3, 1);

    // ALU_W_OP, even parity, P=8.
    clear_counts();
    send(2'd2, 4'h0, 8'h12, 8'h07, 4'h1, 1'b1, 1'b0, 16'd8);
    wait_frame(1, 2000);
    check_frame("alu_w_op", 384, 4, 1);

    // REG_RD, odd parity, P=0 behaves as P=1.
    clear_counts();
    send(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 16'd0);
    wait_frame(1, 200);
    check_frame("reg_rd_p0", 24, 2, 1);

    // Inputs changed mid-frame do not disturb the frame in flight.
    clear_counts();
    send(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 16'd4);
    repeat (50) cycle();
    cmd_if.cmd_op_a = 8'h99;
    clks_per_bit    = 16'd2;
    wait_frame(1, 1000);
    check_frame("midchg_old", 132, 3, 1);
    clear_counts();
    send(2'd0, 4'h5, 8'h99, 8'h00, 4'h0, 1'b0, 1'b0, 16'd2);
    wait_frame(1, 1000);
    check_frame("midchg_new", 66, 3, 1);

    // cmd_valid held high: second command starts right after frame_done.
    clear_counts();
    drive(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 16'd2);
    push_frame(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 16'd2);
    push_frame(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 16'd2);
    cmd_if.cmd_valid = 1'b1;
    cycle();
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      cycle();
      n++;
    end
    check("b2b_fd_seen", 32'(frame_done), 32'd1);
    check("b2b_ready_in_fd", 32'(cmd_if.cmd_ready), 32'd1);
    cycle();
    check("b2b_busy_again", 32'(busy), 32'd1);
    check("b2b_start_bit", 32'(tx_out), 32'd0);
    cmd_if.cmd_valid = 1'b0;
    wait_frame(2, 1000);
    check_frame("b2b", 88, 4, 2);

    // Asynchronous reset mid-DATA of the second byte.
    clear_counts();
    send(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 16'd4);
    repeat (52) cycle();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    sb.delete();
    repeat (2) cycle();
    RST = 1'b0;
    cycle();
    clear_counts();
    send(2'd3, 4'h0, 8'h00, 8'h00, 4'h9, 1'b0, 1'b0, 16'd4);
    wait_frame(1, 1000);
    check_frame("post_rst", 88, 2, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
